// File: rtl/song_scheduler.sv
// song_scheduler: beat clock generation and playback arbitration between four
// song players and a piano key. One clock domain (clk_5MHz); all outputs are
// registered.
module song_scheduler #(
    parameter int BEAT_HALF = 625000,
    parameter int GAP_BEATS = 4,
    parameter bit AUTO_ADV  = 1'b1
) (
    input  logic       clk_5MHz,
    input  logic       rst,
    input  logic       play,
    input  logic       stop,
    input  logic       next,
    input  logic       key_req,
    input  logic       key_beep,
    input  logic [3:0] song_beep,
    input  logic [3:0] song_done,
    output logic       clk_4Hz,
    output logic [3:0] select,
    output logic       beep,
    output logic [1:0] cur_song,
    output logic [1:0] mode
);

    localparam int CNT_W = (BEAT_HALF > 1) ? $clog2(BEAT_HALF) : 1;
    // One spare code so the counter can hold GAP_BEATS itself (also safe for GAP_BEATS = 0).
    localparam int GAP_W = $clog2(GAP_BEATS + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_HALF - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_BEATS);

    // State encoding doubles as the mode output code.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PIANO = 2'b10,
        ST_GAP   = 2'b11
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot4 = 4'b0001;
            2'd1:    onehot4 = 4'b0010;
            2'd2:    onehot4 = 4'b0100;
            2'd3:    onehot4 = 4'b1000;
            default: onehot4 = 4'b0000;
        endcase
    endfunction

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             clk_4hz_q, clk_4hz_d;
    state_t           state_q, state_d;
    state_t           resume_q, resume_d;
    logic [1:0]       cur_song_q, cur_song_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [3:0]       song_done_q;
    logic [3:0]       select_q, select_d;
    logic             beep_q, beep_d;

    logic             beat_wrap_s;
    logic             beat_tick_s;
    logic             done_evt_s;
    logic [GAP_W-1:0] gap_next_s;

    // Free-running half-period counter; the beat clock toggles on each wrap.
    always_comb begin
        beat_wrap_s = (beat_cnt_q == CNT_LAST);
        if (beat_wrap_s) begin
            beat_cnt_d = '0;
            clk_4hz_d  = ~clk_4hz_q;
        end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            clk_4hz_d  = clk_4hz_q;
        end
        // Pulse in the cycle whose edge drives the beat clock 0 -> 1.
        beat_tick_s = beat_wrap_s & ~clk_4hz_q;
    end

    // Rising edge of the current song's done flag only; gap beat accumulation.
    always_comb begin
        done_evt_s = song_done[cur_song_q] & ~song_done_q[cur_song_q];
        gap_next_s = gap_cnt_q + GAP_W'(beat_tick_s);
    end

    // Playback state machine with fixed event priority: stop > key > next > done > play.
    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        cur_song_d = cur_song_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (key_req) begin
                    state_d  = ST_PIANO;
                    resume_d = ST_IDLE;
                end else if (next) begin
                    cur_song_d = cur_song_q + 2'd1;
                end else if (done_evt_s) begin
                    state_d = ST_IDLE;
                end else if (play) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (key_req) begin
                    state_d  = ST_PIANO;
                    resume_d = ST_PLAY;
                end else if (next) begin
                    cur_song_d = cur_song_q + 2'd1;
                    state_d    = ST_GAP;
                    gap_cnt_d  = '0;
                end else if (done_evt_s) begin
                    if (AUTO_ADV) begin
                        cur_song_d = cur_song_q + 2'd1;
                        state_d    = ST_GAP;
                        gap_cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_PIANO: begin
                if (stop) begin
                    // Stop while the key is held only cancels the resume target.
                    resume_d = ST_IDLE;
                    if (key_req) begin
                        state_d = ST_PIANO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!key_req) begin
                    state_d = resume_q;
                end else begin
                    state_d = ST_PIANO;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (key_req) begin
                    // Gap is abandoned; releasing the key starts the new song at once.
                    state_d  = ST_PIANO;
                    resume_d = ST_PLAY;
                end else if (next) begin
                    cur_song_d = cur_song_q + 2'd1;
                    gap_cnt_d  = '0;
                end else if (gap_next_s >= GAP_END) begin
                    state_d   = ST_PLAY;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_next_s;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                resume_d   = ST_IDLE;
                cur_song_d = 2'd0;
                gap_cnt_d  = '0;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        if (state_d == ST_PLAY) begin
            select_d = onehot4(cur_song_d);
        end else begin
            select_d = 4'b0000;
        end
        case (state_q)
            ST_PLAY:  beep_d = song_beep[cur_song_q];
            ST_PIANO: beep_d = key_beep;
            default:  beep_d = 1'b0;
        endcase
    end

    // All state and output registers with synchronous reset.
    always_ff @(posedge clk_5MHz) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            clk_4hz_q   <= 1'b0;
            state_q     <= ST_IDLE;
            resume_q    <= ST_IDLE;
            cur_song_q  <= 2'd0;
            gap_cnt_q   <= '0;
            song_done_q <= 4'b0000;
            select_q    <= 4'b0000;
            beep_q      <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            clk_4hz_q   <= clk_4hz_d;
            state_q     <= state_d;
            resume_q    <= resume_d;
            cur_song_q  <= cur_song_d;
            gap_cnt_q   <= gap_cnt_d;
            song_done_q <= song_done;
            select_q    <= select_d;
            beep_q      <= beep_d;
        end
    end

    assign clk_4Hz  = clk_4hz_q;
    assign select   = select_q;
    assign beep     = beep_q;
    assign cur_song = cur_song_q;
    assign mode     = state_q;

endmodule

// File: tb/tb_song_scheduler.sv
// Directed testbench for song_scheduler (BEAT_HALF=4, GAP_BEATS=2, AUTO_ADV=1).
module tb_song_scheduler;

    logic       clk = 1'b0;
    logic       rst, play, stop, next, key_req, key_beep;
    logic [3:0] song_beep, song_done;
    logic       clk_4Hz, beep;
    logic [3:0] select;
    logic [1:0] cur_song, mode;

    int n_checks = 0;
    int n_fail   = 0;

    song_scheduler #(.BEAT_HALF(4), .GAP_BEATS(2), .AUTO_ADV(1'b1)) dut (
        .clk_5MHz(clk), .rst(rst), .play(play), .stop(stop), .next(next),
        .key_req(key_req), .key_beep(key_beep), .song_beep(song_beep),
        .song_done(song_done), .clk_4Hz(clk_4Hz), .select(select),
        .beep(beep), .cur_song(cur_song), .mode(mode)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; play = 1'b0; stop = 1'b0; next = 1'b0; key_req = 1'b0;
        key_beep = 1'b0; song_beep = 4'b0000; song_done = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_play();
        play = 1'b1; tick(); play = 1'b0;
    endtask

    task automatic pulse_next();
        next = 1'b1; tick(); next = 1'b0;
    endtask

    task automatic test_reset();
        int errs;
        int toggles;
        logic prev;
        logic exp_clk;
        do_reset();
        n_checks++; if (mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b expected 00", mode); end
        n_checks++; if (cur_song !== 2'd0) begin n_fail++; $display("FAIL reset_song: got %0d expected 0", cur_song); end
        n_checks++; if (select !== 4'b0000 || beep !== 1'b0 || clk_4Hz !== 1'b0) begin
            n_fail++; $display("FAIL reset_outs: select=%b beep=%b clk_4Hz=%b expected 0000/0/0", select, beep, clk_4Hz); end
        errs = 0; toggles = 0; prev = clk_4Hz;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_clk = ((k / 4) % 2) == 1;
            if (clk_4Hz !== exp_clk || select !== 4'b0000 || beep !== 1'b0) errs++;
            if (clk_4Hz !== prev) toggles++;
            prev = clk_4Hz;
        end
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL idle_beat_pattern: %0d bad cycles, expected 0", errs); end
        n_checks++; if (toggles !== 10) begin n_fail++; $display("FAIL idle_beat_toggles: got %0d expected 10", toggles); end
    endtask

    task automatic test_play();
        do_reset();
        song_beep = 4'b0001;
        pulse_play();
        n_checks++; if (mode !== 2'b01) begin n_fail++; $display("FAIL play_mode: got %b expected 01", mode); end
        n_checks++; if (select !== 4'b0001) begin n_fail++; $display("FAIL play_select: got %b expected 0001", select); end
        n_checks++; if (beep !== 1'b0) begin n_fail++; $display("FAIL play_beep_latency: got %b expected 0", beep); end
        tick();
        n_checks++; if (beep !== 1'b1) begin n_fail++; $display("FAIL play_beep_hi: got %b expected 1", beep); end
        song_beep = 4'b0000; tick();
        n_checks++; if (beep !== 1'b0) begin n_fail++; $display("FAIL play_beep_lo: got %b expected 0", beep); end
        song_beep = 4'b0010; tick();
        n_checks++; if (beep !== 1'b0) begin n_fail++; $display("FAIL play_beep_other_song: got %b expected 0", beep); end
        song_beep = 4'b0000;
        pulse_play();
        n_checks++; if (mode !== 2'b01 || select !== 4'b0001) begin
            n_fail++; $display("FAIL play_ignored_in_play: mode=%b select=%b expected 01/0001", mode, select); end
    endtask

    task automatic test_song_end();
        int rises;
        logic prev;
        logic reached;
        do_reset();
        pulse_next(); pulse_next(); pulse_next();
        n_checks++; if (cur_song !== 2'd3 || mode !== 2'b00) begin
            n_fail++; $display("FAIL idle_next3: cur_song=%0d mode=%b expected 3/00", cur_song, mode); end
        pulse_play();
        n_checks++; if (select !== 4'b1000) begin n_fail++; $display("FAIL play_song3_select: got %b expected 1000", select); end
        song_done = 4'b0100; tick();
        n_checks++; if (mode !== 2'b01) begin n_fail++; $display("FAIL done_other_ignored: mode=%b expected 01", mode); end
        song_done = 4'b1100; tick();
        song_done = 4'b0000;
        n_checks++; if (mode !== 2'b11 || cur_song !== 2'd0 || select !== 4'b0000) begin
            n_fail++; $display("FAIL done_to_gap: mode=%b cur_song=%0d select=%b expected 11/0/0000", mode, cur_song, select); end
        rises = 0; prev = clk_4Hz; reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (clk_4Hz === 1'b1 && prev === 1'b0) rises++;
            prev = clk_4Hz;
            if (mode === 2'b01) begin reached = 1'b1; break; end
        end
        n_checks++; if (reached !== 1'b1) begin n_fail++; $display("FAIL gap_timeout: mode=%b expected 01 within 40 cycles", mode); end
        n_checks++; if (rises !== 2) begin n_fail++; $display("FAIL gap_beats: got %0d beat ticks expected 2", rises); end
        n_checks++; if (select !== 4'b0001) begin n_fail++; $display("FAIL gap_to_play_select: got %b expected 0001", select); end
    endtask

    task automatic test_gap_next();
        int rises;
        logic prev;
        logic reached;
        pulse_next();
        n_checks++; if (mode !== 2'b11 || cur_song !== 2'd1) begin
            n_fail++; $display("FAIL play_next_gap: mode=%b cur_song=%0d expected 11/1", mode, cur_song); end
        prev = clk_4Hz; reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clk_4Hz === 1'b1 && prev === 1'b0) begin reached = 1'b1; break; end
            prev = clk_4Hz;
        end
        n_checks++; if (reached !== 1'b1 || mode !== 2'b11) begin
            n_fail++; $display("FAIL gap_first_beat: seen=%b mode=%b expected 1/11", reached, mode); end
        pulse_next();
        n_checks++; if (mode !== 2'b11 || cur_song !== 2'd2) begin
            n_fail++; $display("FAIL gap_next: mode=%b cur_song=%0d expected 11/2", mode, cur_song); end
        rises = 0; prev = clk_4Hz; reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (clk_4Hz === 1'b1 && prev === 1'b0) rises++;
            prev = clk_4Hz;
            if (mode === 2'b01) begin reached = 1'b1; break; end
        end
        n_checks++; if (reached !== 1'b1 || rises !== 2) begin
            n_fail++; $display("FAIL gap_restart: reached=%b beats=%0d expected 1/2", reached, rises); end
        n_checks++; if (select !== 4'b0100) begin n_fail++; $display("FAIL gap_restart_select: got %b expected 0100", select); end
    endtask

    task automatic test_piano();
        int errs;
        do_reset();
        pulse_next();
        pulse_play();
        n_checks++; if (select !== 4'b0010) begin n_fail++; $display("FAIL piano_pre_select: got %b expected 0010", select); end
        key_req = 1'b1; tick();
        n_checks++; if (mode !== 2'b10 || select !== 4'b0000) begin
            n_fail++; $display("FAIL piano_enter: mode=%b select=%b expected 10/0000", mode, select); end
        key_beep = 1'b1; tick();
        n_checks++; if (beep !== 1'b1) begin n_fail++; $display("FAIL piano_beep_hi: got %b expected 1", beep); end
        key_beep = 1'b0; song_beep = 4'b0010; tick();
        n_checks++; if (beep !== 1'b0) begin n_fail++; $display("FAIL piano_beep_lo: got %b expected 0", beep); end
        pulse_play();
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (mode !== 2'b10 || select !== 4'b0000 || beep !== 1'b0) errs++;
        end
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL piano_hold: %0d bad cycles expected 0", errs); end
        key_req = 1'b0; tick();
        n_checks++; if (mode !== 2'b01 || select !== 4'b0010) begin
            n_fail++; $display("FAIL piano_resume: mode=%b select=%b expected 01/0010", mode, select); end
        tick();
        n_checks++; if (beep !== 1'b1) begin n_fail++; $display("FAIL resume_song_beep: got %b expected 1", beep); end
        song_beep = 4'b0000;
    endtask

    task automatic test_stop_key();
        stop = 1'b1; key_req = 1'b1; tick(); stop = 1'b0;
        n_checks++; if (mode !== 2'b00 || select !== 4'b0000) begin
            n_fail++; $display("FAIL stop_beats_key: mode=%b select=%b expected 00/0000", mode, select); end
        tick();
        n_checks++; if (mode !== 2'b10) begin n_fail++; $display("FAIL idle_key_piano: mode=%b expected 10", mode); end
        key_req = 1'b0; tick();
        n_checks++; if (mode !== 2'b00) begin n_fail++; $display("FAIL piano_resume_idle: mode=%b expected 00", mode); end
        pulse_play();
        key_req = 1'b1; tick();
        stop = 1'b1; tick(); stop = 1'b0;
        n_checks++; if (mode !== 2'b10) begin n_fail++; $display("FAIL piano_stop_held: mode=%b expected 10", mode); end
        key_req = 1'b0; tick();
        n_checks++; if (mode !== 2'b00 || select !== 4'b0000) begin
            n_fail++; $display("FAIL piano_stop_release: mode=%b select=%b expected 00/0000", mode, select); end
    endtask

    task automatic test_priority();
        do_reset();
        next = 1'b1; play = 1'b1; tick(); next = 1'b0; play = 1'b0;
        n_checks++; if (mode !== 2'b00 || cur_song !== 2'd1) begin
            n_fail++; $display("FAIL prio_next_over_play: mode=%b cur_song=%0d expected 00/1", mode, cur_song); end
        key_req = 1'b1; next = 1'b1; play = 1'b1; tick(); next = 1'b0; play = 1'b0;
        n_checks++; if (mode !== 2'b10 || cur_song !== 2'd1) begin
            n_fail++; $display("FAIL prio_key_over_next: mode=%b cur_song=%0d expected 10/1", mode, cur_song); end
        key_req = 1'b0; tick();
        n_checks++; if (mode !== 2'b00) begin n_fail++; $display("FAIL prio_release_idle: mode=%b expected 00", mode); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        for (int i = 0; i < 5; i++) pulse_next();
        n_checks++; if (cur_song !== 2'd1) begin n_fail++; $display("FAIL next_wrap: cur_song=%0d expected 1", cur_song); end
        pulse_play();
        pulse_next();
        n_checks++; if (mode !== 2'b11 || cur_song !== 2'd2) begin
            n_fail++; $display("FAIL pre_rst_gap: mode=%b cur_song=%0d expected 11/2", mode, cur_song); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if (mode !== 2'b00 || cur_song !== 2'd0 || select !== 4'b0000 || beep !== 1'b0 || clk_4Hz !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_gap: mode=%b cur_song=%0d select=%b beep=%b clk_4Hz=%b expected 00/0/0000/0/0",
                               mode, cur_song, select, beep, clk_4Hz); end
        pulse_play();
        key_req = 1'b1; key_beep = 1'b1; tick(); tick();
        n_checks++; if (mode !== 2'b10 || beep !== 1'b1) begin
            n_fail++; $display("FAIL pre_rst_piano: mode=%b beep=%b expected 10/1", mode, beep); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if (mode !== 2'b00 || beep !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_piano: mode=%b beep=%b expected 00/0", mode, beep); end
        key_req = 1'b0; key_beep = 1'b0;
    endtask

    initial begin
        test_reset();
        test_play();
        test_song_end();
        test_gap_next();
        test_piano();
        test_stop_key();
        test_priority();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
